// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes one shared two-digit decoder over the
// hours/minutes/seconds fields and drives a 6-digit common-anode display.
// The shadow registers change only at frame boundaries so that a frame never
// tears. Each slot starts with guard blanking, and fields can blink in set mode.
module display_scan_controller #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hours,
  input  logic [5:0]  minutes,
  input  logic [5:0]  seconds,
  input  logic        load,
  input  logic [1:0]  blink_sel,
  input  logic        blink_tick,
  output logic [5:0]  dec_in,
  input  logic [0:13] dec_seg,
  output logic [0:6]  seg,
  output logic [0:5]  an,
  output logic        frame_done
);

  localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] CNT_GUARD = 16'(GUARD);

  typedef enum logic [2:0] {
    SLOT_HT = 3'd0,
    SLOT_HU = 3'd1,
    SLOT_MT = 3'd2,
    SLOT_MU = 3'd3,
    SLOT_ST = 3'd4,
    SLOT_SU = 3'd5
  } slot_t;

  slot_t       idx;
  logic [15:0] cnt;
  logic        blink_phase;
  logic [5:0]  sh_h, sh_m, sh_s;
  logic [5:0]  pend_h, pend_m, pend_s;
  logic        pending_valid;

  logic        slot_wrap;
  logic        frame_end;
  logic [1:0]  field;
  logic        units;
  logic        blank;
  logic [0:5]  an_next;
  logic [0:6]  seg_next;

  assign slot_wrap = (cnt == CNT_LAST);
  assign frame_end = slot_wrap && (idx == SLOT_SU);

  // Field/digit decode of the current slot and the shared decoder input
  always_comb begin
    field = 2'b01;
    units = 1'b0;
    case (idx)
      SLOT_HT: begin field = 2'b01; units = 1'b0; end
      SLOT_HU: begin field = 2'b01; units = 1'b1; end
      SLOT_MT: begin field = 2'b10; units = 1'b0; end
      SLOT_MU: begin field = 2'b10; units = 1'b1; end
      SLOT_ST: begin field = 2'b11; units = 1'b0; end
      SLOT_SU: begin field = 2'b11; units = 1'b1; end
      default: begin field = 2'b01; units = 1'b0; end
    endcase
    case (field)
      2'b10:   dec_in = sh_m;
      2'b11:   dec_in = sh_s;
      default: dec_in = sh_h;
    endcase
  end

  // Next values of the registered display outputs
  always_comb begin
    blank   = blink_phase && (blink_sel == field);
    an_next = '1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (cnt >= CNT_GUARD && idx == slot_t'(3'(i))) an_next[i] = 1'b0;
    end
    if (blank)      seg_next = '1;
    else if (units) seg_next = dec_seg[7:13];
    else            seg_next = dec_seg[0:6];
  end

  // Slot prescaler and digit-index sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= SLOT_HT;
    end else if (slot_wrap) begin
      cnt <= '0;
      case (idx)
        SLOT_HT: idx <= SLOT_HU;
        SLOT_HU: idx <= SLOT_MT;
        SLOT_MT: idx <= SLOT_MU;
        SLOT_MU: idx <= SLOT_ST;
        SLOT_ST: idx <= SLOT_SU;
        default: idx <= SLOT_HT;
      endcase
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Registered pin drivers, one cycle behind the scan position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= '1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= an_next;
      frame_done <= frame_end;
    end
  end

  // Blink phase toggles on every tick, independent of blink_sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_phase <= 1'b0;
    else if (blink_tick) blink_phase <= ~blink_phase;
  end

  // Pending capture and frame-boundary shadow update; a load landing on the
  // boundary itself bypasses the pending stage so there is no frame of delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_h          <= '0;
      sh_m          <= '0;
      sh_s          <= '0;
      pend_h        <= '0;
      pend_m        <= '0;
      pend_s        <= '0;
      pending_valid <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        sh_h <= hours;
        sh_m <= minutes;
        sh_s <= seconds;
      end else if (pending_valid) begin
        sh_h <= pend_h;
        sh_m <= pend_m;
        sh_s <= pend_s;
      end
      pending_valid <= 1'b0;
    end else if (load) begin
      pend_h        <= hours;
      pend_m        <= minutes;
      pend_s        <= seconds;
      pending_valid <= 1'b1;
    end
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared two-digit decoder across hours, minutes and seconds, and drives a 6-digit common-anode display with active-low segments and active-low digit enables.
- The decoder takes a 6-bit value (0..59) and returns 14 active-low segments: [0:6] tens, [7:13] units.
- The controller sits between the timekeeping counters and the display pins.
- It provides tear-free frame updates, anti-ghosting guard blanking and set-mode blinking.

Parameters:
- SCAN_DIV, 1000, clock cycles each digit slot lasts (legal range 2..65535).
- GUARD, 2, cycles at the start of each slot during which all digit enables are off (legal range 1..SCAN_DIV-1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- hours  input  6  hours value, 0..23.
- minutes  input  6  minutes value, 0..59.
- seconds  input  6  seconds value, 0..59.
- load  input  1  single-cycle strobe that captures hours, minutes and seconds.
- blink_sel  input  2  field to blink: 00 none, 01 hours, 10 minutes, 11 seconds.
- blink_tick  input  1  single-cycle strobe that toggles the blink phase.
- dec_in  output  6  value driven to the shared decoder.
- dec_seg  input  14  combinational decoder result for dec_in, active-low, [0:6] tens, [7:13] units.
- seg  output  [0:6]  segments a..g, active-low, registered.
- an  output  [0:5]  digit enables, active-low, registered; an[0]=hours tens … an[5]=seconds units.
- frame_done  output  1  one-cycle pulse at the end of each 6-digit frame.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - cnt=0, idx=0, blink_phase=0.
  - Shadow h/m/s = 0, pending registers = 0, pending_valid=0.
  - seg=7'b1111111, an=6'b111111, frame_done=0, so dec_in=0.
  - Reset asserted mid-frame abandons the frame; scanning restarts at idx 0, cnt 0 after release.
- Prescaler cnt: counts 0..SCAN_DIV-1 and wraps. On wrap, idx advances 0→1→…→5→0.
- Digit index idx (0..5) selects the field and the digit:
  - Field: idx 0,1 hours; idx 2,3 minutes; idx 4,5 seconds.
  - Even idx selects the tens digit (dec_seg[0:6]); odd idx selects the units digit (dec_seg[7:13]).
- dec_in: combinational from the shadow register of the current field.
- Registered outputs, updated every clock from the current cnt/idx (one-cycle latency):
  - an: 6'b111111 when cnt < GUARD; otherwise only bit idx is low.
  - seg: the selected slice of dec_seg, or 7'b1111111 if blanked.
- Blanking: seg is blanked when blink_phase=1 and blink_sel selects the current field.
- Blink phase: blink_phase toggles on each blink_tick.
  - Setting blink_sel=00 never blanks, but the phase keeps toggling.
- Load and shadow update:
  - load copies hours/minutes/seconds into the pending registers and sets pending_valid; a later load overwrites earlier pending values.
  - The frame boundary is the cycle with idx=5 and cnt=SCAN_DIV-1. At that edge, if pending_valid, the shadows take the pending values and pending_valid clears.
  - If load coincides with the frame boundary, the shadows take the live load inputs directly (bypass) and pending_valid stays 0.
  - Shadows never change mid-frame.
- frame_done: registered, high for exactly one cycle, on the cycle after the frame boundary edge.
- Out-of-range values (e.g. 60..63) are captured unchanged; the decoder's default output (00) is what gets displayed.
- No combinational path from any input to seg, an or frame_done.

Test Plan:
1. Reset, then release with SCAN_DIV=4, GUARD=1:
   - Outputs are an=111111, seg=1111111 at reset.
   - Afterwards the an low bit steps 0..5, each held 3 cycles after a 1-cycle all-high guard.
   - frame_done pulses once every 24 cycles.
2. load with h=12, m=34, s=56 mid-frame:
   - The current frame keeps showing 00:00:00.
   - The next frame shows digit patterns 1,2,3,4,5,6 (e.g. idx1 seg=0010010, idx5 seg=0100000).
3. load asserted exactly on the frame-boundary cycle with h=07:
   - The next frame shows 0,7 on idx 0,1 with no one-frame delay.
   - Two loads in one frame (h=05, then h=09): only 09 is displayed.
4. blink_sel=10, blink_tick pulsed once:
   - idx 2,3 show seg=1111111 while an still steps normally; hours and seconds are unaffected.
   - A second blink_tick restores the minutes digits.
5. rst pulsed while idx=3, cnt=2 (asynchronous, between clock edges):
   - Outputs go to reset values immediately.
   - After release, scanning restarts at idx 0 and the shadows read 00.
6. load with m=61:
   - idx 2,3 display the decoder's default pattern 0000001, 0000001; no hang and no idx corruption.
